// File: rtl/wishbone_bus_arbiter.sv
// wishbone_bus_arbiter: two-master round-robin Wishbone arbiter; optional timeout via WB_ARBITER_TIMEOUT_EN
module wishbone_bus_arbiter #(
    parameter int ADDR_SIZE      = 32,
    parameter int DATA_SIZE      = 32,
    parameter int BYTE_AMNT      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 CLK_I,
    input  logic                 RST_I,
    input  logic                 m0_CYC_I,
    input  logic                 m0_STB_I,
    input  logic                 m0_WE_I,
    input  logic [BYTE_AMNT-1:0] m0_SEL_I,
    input  logic [ADDR_SIZE-1:0] m0_ADR_I,
    input  logic [DATA_SIZE-1:0] m0_DAT_I,
    output logic [DATA_SIZE-1:0] m0_DAT_O,
    output logic                 m0_ACK_O,
    output logic                 m0_ERR_O,
    input  logic                 m1_CYC_I,
    input  logic                 m1_STB_I,
    input  logic                 m1_WE_I,
    input  logic [BYTE_AMNT-1:0] m1_SEL_I,
    input  logic [ADDR_SIZE-1:0] m1_ADR_I,
    input  logic [DATA_SIZE-1:0] m1_DAT_I,
    output logic [DATA_SIZE-1:0] m1_DAT_O,
    output logic                 m1_ACK_O,
    output logic                 m1_ERR_O,
    output logic                 s_CYC_O,
    output logic                 s_STB_O,
    output logic                 s_WE_O,
    output logic [BYTE_AMNT-1:0] s_SEL_O,
    output logic [ADDR_SIZE-1:0] s_ADR_O,
    output logic [DATA_SIZE-1:0] s_DAT_O,
    input  logic [DATA_SIZE-1:0] s_DAT_I,
    input  logic                 s_ACK_I,
    output logic [1:0]           grant_o
);
    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
    state_t state_q, state_d;
    logic   last_grant_q, last_grant_d;
    logic   req0, req1, busy, own0, own1, cyc_x, tmo;
    assign req0  = m0_CYC_I & m0_STB_I;
    assign req1  = m1_CYC_I & m1_STB_I;
    assign own0  = state_q == GNT0;
    assign own1  = state_q == GNT1;
    assign busy  = own0 | own1;
    assign cyc_x = own1 ? m1_CYC_I : m0_CYC_I;
`ifdef WB_ARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tmo = busy & ~s_ACK_I & (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    // Count grant cycles without ACK; idle cycles park it at zero for the next grant
    always_comb begin
        cnt_d = (busy & ~s_ACK_I) ? cnt_q + 1'b1 : '0;
    end
    // Timeout counter register
    always_ff @(posedge CLK_I) begin
        if (!RST_I) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign tmo = 1'b0;
`endif
    // Next-state: round-robin pick in IDLE, release on ACK, abort or timeout
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        if (!busy) begin
            state_d = (req0 && (!req1 || last_grant_q)) ? GNT0 : req1 ? GNT1 : IDLE;
        end else if (s_ACK_I || !cyc_x || tmo) begin
            state_d      = IDLE;
            last_grant_d = own1;
        end
    end
    // State and fairness registers
    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
        end
    end
    // Route the owner onto the slave and the slave response back to the owner only
    always_comb begin
        s_CYC_O  = busy & cyc_x & ~tmo;
        s_STB_O  = busy & (own1 ? m1_STB_I : m0_STB_I) & ~tmo;
        s_WE_O   = busy & (own1 ? m1_WE_I : m0_WE_I);
        s_SEL_O  = !busy ? '0 : own1 ? m1_SEL_I : m0_SEL_I;
        s_ADR_O  = !busy ? '0 : own1 ? m1_ADR_I : m0_ADR_I;
        s_DAT_O  = !busy ? '0 : own1 ? m1_DAT_I : m0_DAT_I;
        m0_ACK_O = own0 & s_ACK_I;
        m1_ACK_O = own1 & s_ACK_I;
        m0_ERR_O = own0 & tmo;
        m1_ERR_O = own1 & tmo;
        m0_DAT_O = s_DAT_I;
        m1_DAT_O = s_DAT_I;
        grant_o  = {own1, own0};
    end
endmodule

// File: tb/tb_wishbone_bus_arbiter.sv
// tb_wishbone_bus_arbiter: directed self-checking bench for the round-robin Wishbone arbiter
module tb_wishbone_bus_arbiter;
    logic        CLK_I = 0, RST_I = 0;
    logic        m0_CYC_I = 0, m0_STB_I = 0, m0_WE_I = 0;
    logic [3:0]  m0_SEL_I = 0;
    logic [31:0] m0_ADR_I = 0, m0_DAT_I = 0, m0_DAT_O;
    logic        m0_ACK_O, m0_ERR_O;
    logic        m1_CYC_I = 0, m1_STB_I = 0, m1_WE_I = 0;
    logic [3:0]  m1_SEL_I = 0;
    logic [31:0] m1_ADR_I = 0, m1_DAT_I = 0, m1_DAT_O;
    logic        m1_ACK_O, m1_ERR_O;
    logic        s_CYC_O, s_STB_O, s_WE_O, s_ACK_I = 0;
    logic [3:0]  s_SEL_O;
    logic [31:0] s_ADR_O, s_DAT_O, s_DAT_I = 0;
    logic [1:0]  grant_o;
    int          tests = 0, fails = 0;

    wishbone_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I),
        .m0_CYC_I(m0_CYC_I), .m0_STB_I(m0_STB_I), .m0_WE_I(m0_WE_I), .m0_SEL_I(m0_SEL_I),
        .m0_ADR_I(m0_ADR_I), .m0_DAT_I(m0_DAT_I), .m0_DAT_O(m0_DAT_O), .m0_ACK_O(m0_ACK_O), .m0_ERR_O(m0_ERR_O),
        .m1_CYC_I(m1_CYC_I), .m1_STB_I(m1_STB_I), .m1_WE_I(m1_WE_I), .m1_SEL_I(m1_SEL_I),
        .m1_ADR_I(m1_ADR_I), .m1_DAT_I(m1_DAT_I), .m1_DAT_O(m1_DAT_O), .m1_ACK_O(m1_ACK_O), .m1_ERR_O(m1_ERR_O),
        .s_CYC_O(s_CYC_O), .s_STB_O(s_STB_O), .s_WE_O(s_WE_O), .s_SEL_O(s_SEL_O),
        .s_ADR_O(s_ADR_O), .s_DAT_O(s_DAT_O), .s_DAT_I(s_DAT_I), .s_ACK_I(s_ACK_I), .grant_o(grant_o)
    );

    always #5 CLK_I = ~CLK_I;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_I);
        #2;
    endtask

    task automatic req(input int m, input logic on);
        if (m == 0) begin m0_CYC_I = on; m0_STB_I = on; end
        else        begin m1_CYC_I = on; m1_STB_I = on; end
    endtask

    initial begin
        step(); step();
        chk("rst_grant", {30'd0, grant_o}, 32'd0);
        chk("rst_cyc", {31'd0, s_CYC_O}, 32'd0);
        chk("rst_acks", {28'd0, m0_ACK_O, m1_ACK_O, m0_ERR_O, m1_ERR_O}, 32'd0);
        RST_I = 1;
        step();

        m0_ADR_I = 32'h10; m0_SEL_I = 4'hF; req(0, 1);
        #1 chk("m0_req_same_cycle", {30'd0, grant_o}, 32'd0);
        step();
        chk("m0_grant", {30'd0, grant_o}, 32'd1);
        chk("m0_adr", s_ADR_O, 32'h10);
        chk("m0_we", {31'd0, s_WE_O}, 32'd0);
        chk("m0_cyc", {31'd0, s_CYC_O}, 32'd1);
        s_ACK_I = 1; s_DAT_I = 32'hCAFE0001;
        #1 chk("m0_ack", {30'd0, m0_ACK_O, m1_ACK_O}, 32'b10);
        chk("m0_dat", m0_DAT_O, 32'hCAFE0001);
        step();
        req(0, 0);
        #1 chk("idle_ack_ignored", {30'd0, m0_ACK_O, m1_ACK_O}, 32'd0);
        chk("idle_after_ack", {30'd0, grant_o}, 32'd0);
        s_ACK_I = 0;

        RST_I = 0; step(); RST_I = 1;
        m0_ADR_I = 32'h100; m1_ADR_I = 32'h200; m1_WE_I = 1;
        req(0, 1); req(1, 1);
        step();
        chk("both_first_m0", {30'd0, grant_o}, 32'd1);
        chk("both_adr0", s_ADR_O, 32'h100);
        s_ACK_I = 1;
        step();
        s_ACK_I = 0;
        #1 chk("both_idle_gap", {30'd0, grant_o}, 32'd0);
        chk("both_idle_cyc", {31'd0, s_CYC_O}, 32'd0);
        step();
        chk("both_then_m1", {30'd0, grant_o}, 32'd2);
        chk("both_adr1", s_ADR_O, 32'h200);
        chk("both_we1", {31'd0, s_WE_O}, 32'd1);

        for (int i = 0; i < 6; i++) begin
            s_ACK_I = 1;
            step();
            s_ACK_I = 0;
            #1 chk("rr_idle", {30'd0, grant_o}, 32'd0);
            step();
            chk("rr_grant", {30'd0, grant_o}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end

        m1_ADR_I = 32'h01000004; m1_WE_I = 1; m1_SEL_I = 4'h5; m1_DAT_I = 32'hDEADBEEF;
        #1 chk("wr_adr", s_ADR_O, 32'h01000004);
        chk("wr_sel", {28'd0, s_SEL_O}, 32'h5);
        chk("wr_dat", s_DAT_O, 32'hDEADBEEF);
        chk("wr_we", {31'd0, s_WE_O}, 32'd1);
        req(1, 0);
        #1 chk("abort_cyc", {31'd0, s_CYC_O}, 32'd0);
        step();
        chk("abort_idle", {30'd0, grant_o}, 32'd0);
        step();
        chk("abort_m0_next", {30'd0, grant_o}, 32'd1);
        s_ACK_I = 1;
        step();
        s_ACK_I = 0; req(0, 0);

        req(1, 1);
        step();
        chk("pre_rst_gnt1", {30'd0, grant_o}, 32'd2);
        RST_I = 0; req(0, 1); s_ACK_I = 1;
        step();
        chk("rst_mid_grant", {30'd0, grant_o}, 32'd0);
        chk("rst_mid_cyc", {31'd0, s_CYC_O}, 32'd0);
        chk("rst_mid_acks", {28'd0, m0_ACK_O, m1_ACK_O, m0_ERR_O, m1_ERR_O}, 32'd0);
        s_ACK_I = 0; RST_I = 1;
        step();
        chk("rst_release_m0", {30'd0, grant_o}, 32'd1);

        s_ACK_I = 1;
        step();
        s_ACK_I = 0; req(0, 0);
        step();
        chk("to_grant", {30'd0, grant_o}, 32'd2);
        for (int i = 0; i < 6; i++) step();
        chk("to_no_err_early", {31'd0, m1_ERR_O}, 32'd0);
        step();
`ifdef WB_ARBITER_TIMEOUT_EN
        chk("to_err", {31'd0, m1_ERR_O}, 32'd1);
        chk("to_cyc_drop", {31'd0, s_CYC_O}, 32'd0);
        chk("to_m0_err", {31'd0, m0_ERR_O}, 32'd0);
        step();
        chk("to_idle", {30'd0, grant_o}, 32'd0);
        chk("to_err_pulse", {31'd0, m1_ERR_O}, 32'd0);
`else
        chk("hold_no_err", {31'd0, m1_ERR_O}, 32'd0);
        chk("hold_cyc", {31'd0, s_CYC_O}, 32'd1);
        step();
        chk("hold_grant", {30'd0, grant_o}, 32'd2);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
